// File: rtl/kp_pkg.sv
// Shared types and helpers for the keypad scanner: FSM state encoding and
// the key-code width calculation.
package kp_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kpState_e;

  function automatic int codeWidth(input int keys);
    return (keys <= 2) ? 1 : $clog2(keys);
  endfunction

endpackage

// File: rtl/kp_fifo.sv
// Show-ahead key-code queue; a push into a full queue only lands when a pop
// frees a slot on the same edge.
module kp_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = empty ? '0 : mem[rdPtr[AW-1:0]];

  // Pointers carry an extra wrap bit so full and empty can be told apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: strobes one row at a time, debounces a single key,
// and queues its code for a ready/valid consumer.
module keypad_scanner
  import kp_pkg::*;
#(
  parameter int NUM_SCAN   = 4,
  parameter int NUM_SENSE  = 4,
  parameter int DWELL      = 4,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  output logic [NUM_SCAN-1:0]                            keyPadOut,
  input  logic [NUM_SENSE-1:0]                           keyPadIn,
  output logic [codeWidth(NUM_SCAN*NUM_SENSE)-1:0]       key_code,
  output logic                                           key_valid,
  input  logic                                           key_ready,
  output logic                                           key_held,
  output logic                                           overflow,
  input  logic                                           overflow_clr
);

  localparam int CODE_W = codeWidth(NUM_SCAN * NUM_SENSE);
  localparam int SW     = $clog2(NUM_SCAN);
  localparam int KW     = $clog2(NUM_SENSE);
  localparam int DW     = $clog2(DWELL);
  localparam int CW     = $clog2(DEBOUNCE + 1);

  kpState_e             state;
  logic [NUM_SENSE-1:0] syncA;
  logic [NUM_SENSE-1:0] syncB;
  logic [DW-1:0]        dwellCnt;
  logic [SW-1:0]        scanIdx;
  logic [SW-1:0]        nextIdx;
  logic [CW-1:0]        dbCount;
  logic [KW-1:0]        heldK;
  logic [KW-1:0]        senseK;
  logic                 senseLow;
  logic                 sampleTick;
  logic                 pushReg;
  logic [CODE_W-1:0]    pushCode;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 popReq;
  logic                 dropped;

  function automatic logic [NUM_SCAN-1:0] strobeFor(input logic [SW-1:0] idx);
    logic [NUM_SCAN-1:0] pattern;
    pattern = '1;
    for (int i = 0; i < NUM_SCAN; i++) begin
      if (SW'(i) == idx) pattern[NUM_SCAN-1-i] = 1'b0;
    end
    return pattern;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncA <= '1;
      syncB <= '1;
    end else begin
      syncA <= keyPadIn;
      syncB <= syncA;
    end
  end

  // Scanning from the top sense index down leaves the lowest low k selected.
  always_comb begin
    senseLow = 1'b0;
    senseK   = '0;
    for (int k = NUM_SENSE - 1; k >= 0; k--) begin
      if (!syncB[NUM_SENSE-1-k]) begin
        senseLow = 1'b1;
        senseK   = KW'(k);
      end
    end
  end

  assign sampleTick = (dwellCnt == DW'(DWELL - 1));
  assign nextIdx    = (scanIdx == SW'(NUM_SCAN - 1)) ? '0 : scanIdx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      dwellCnt  <= '0;
      scanIdx   <= '0;
      dbCount   <= '0;
      heldK     <= '0;
      keyPadOut <= {1'b0, {(NUM_SCAN-1){1'b1}}};
      key_held  <= 1'b0;
      pushReg   <= 1'b0;
      pushCode  <= '0;
    end else begin
      pushReg  <= 1'b0;
      dwellCnt <= sampleTick ? '0 : dwellCnt + 1'b1;
      if (sampleTick) begin
        unique case (state)
          SCAN: begin
            if (!senseLow) begin
              scanIdx   <= nextIdx;
              keyPadOut <= strobeFor(nextIdx);
            end else begin
              heldK   <= senseK;
              dbCount <= CW'(1);
              if (DEBOUNCE == 1) begin
                pushReg  <= 1'b1;
                pushCode <= CODE_W'(int'(scanIdx) * NUM_SENSE + int'(senseK));
                key_held <= 1'b1;
                state    <= HELD;
              end else begin
                state <= PRESS_DB;
              end
            end
          end
          PRESS_DB: begin
            if (senseLow && senseK == heldK) begin
              if (dbCount == CW'(DEBOUNCE - 1)) begin
                pushReg  <= 1'b1;
                pushCode <= CODE_W'(int'(scanIdx) * NUM_SENSE + int'(heldK));
                key_held <= 1'b1;
                state    <= HELD;
              end else begin
                dbCount <= dbCount + 1'b1;
              end
            end else begin
              state     <= SCAN;
              scanIdx   <= nextIdx;
              keyPadOut <= strobeFor(nextIdx);
            end
          end
          HELD: begin
            if (!senseLow) begin
              dbCount <= CW'(1);
              if (DEBOUNCE == 1) begin
                key_held  <= 1'b0;
                state     <= SCAN;
                scanIdx   <= nextIdx;
                keyPadOut <= strobeFor(nextIdx);
              end else begin
                state <= RELEASE_DB;
              end
            end
          end
          RELEASE_DB: begin
            if (senseLow) begin
              state <= HELD;
            end else if (dbCount == CW'(DEBOUNCE - 1)) begin
              key_held  <= 1'b0;
              state     <= SCAN;
              scanIdx   <= nextIdx;
              keyPadOut <= strobeFor(nextIdx);
            end else begin
              dbCount <= dbCount + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign popReq    = key_valid && key_ready;
  assign dropped   = pushReg && fifoFull && !popReq;
  assign key_valid = !fifoEmpty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (dropped)      overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

  kp_fifo #(
    .WIDTH(CODE_W),
    .DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (pushReg),
    .pop  (popReq),
    .din  (pushCode),
    .dout (key_code),
    .full (fifoFull),
    .empty(fifoEmpty)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] keyPadOut;
  logic [3:0] keyPadIn;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overflow;
  logic       overflow_clr;
  logic [15:0] keysDown;

  int testsRun;
  int testsFailed;

  keypad_scanner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .keyPadOut   (keyPadOut),
    .keyPadIn    (keyPadIn),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_held    (key_held),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed key shorts its row strobe onto its column sense line.
  always_comb begin
    keyPadIn = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 4; k++) begin
        if (keysDown[s*4+k] && !keyPadOut[3-s]) keyPadIn[3-k] = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input int code, output logic ok);
    keysDown = '0;
    keysDown[code] = 1'b1;
    for (int i = 0; i < 200 && !key_held; i++) @(negedge clk);
    ok = key_held;
    keysDown = '0;
    for (int i = 0; i < 200 && key_held; i++) @(negedge clk);
    ok = ok && !key_held;
  endtask

  task automatic popOne(output logic [3:0] code, output logic valid);
    valid = key_valid;
    code  = key_code;
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    testsRun++;
    if (keyPadOut !== 4'b0111 || key_valid !== 1'b0 || key_held !== 1'b0 ||
        overflow !== 1'b0 || key_code !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: out=%b valid=%b held=%b ovf=%b code=%0d, want 0111 0 0 0 0",
               keyPadOut, key_valid, key_held, overflow, key_code);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_key();
    logic [3:0] code;
    logic       valid;
    logic       ok;
    keysDown = 16'h0001;
    for (int i = 0; i < 200 && !key_held; i++) @(negedge clk);
    testsRun++;
    if (key_held !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL key0_held_timeout: held=%b, want 1", key_held);
    end
    @(negedge clk);
    testsRun++;
    if (key_valid !== 1'b1 || key_code !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL key0_push: valid=%b code=%0d, want 1 0", key_valid, key_code);
    end
    popOne(code, valid);
    testsRun++;
    if (key_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL key0_single_push: valid=%b after pop, want 0", key_valid);
    end
    keysDown = '0;
    repeat (4) @(negedge clk);
    testsRun++;
    if (key_held !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL key0_release_db: held=%b during release debounce, want 1", key_held);
    end
    for (int i = 0; i < 200 && key_held; i++) @(negedge clk);
    ok = !key_held;
    testsRun++;
    if (!ok || key_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL key0_release: held=%b valid=%b, want 0 0", key_held, key_valid);
    end
  endtask

  task automatic test_code5();
    logic       ok;
    logic [3:0] code;
    logic       valid;
    keysDown = '0;
    keysDown[5] = 1'b1;
    for (int i = 0; i < 200 && !key_held; i++) @(negedge clk);
    ok = key_held;
    repeat (2) @(negedge clk);
    testsRun++;
    if (!ok || keyPadOut !== 4'b1011 || key_valid !== 1'b1 || key_code !== 4'd5) begin
      testsFailed++;
      $display("[TB] FAIL key5_code: held=%b out=%b valid=%b code=%0d, want 1 1011 1 5",
               ok, keyPadOut, key_valid, key_code);
    end
    popOne(code, valid);
    keysDown = '0;
    for (int i = 0; i < 200 && key_held; i++) @(negedge clk);
  endtask

  task automatic test_glitch();
    int   cnt;
    logic sawActivity;
    for (int i = 0; i < 40 && keyPadOut == 4'b1101; i++) @(negedge clk);
    for (int i = 0; i < 40 && keyPadOut != 4'b1101; i++) @(negedge clk);
    cnt = 0;
    sawActivity = 1'b0;
    keysDown = '0;
    keysDown[10] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      cnt++;
      if (key_valid || key_held) sawActivity = 1'b1;
    end
    keysDown = '0;
    while (keyPadOut == 4'b1101 && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (key_valid || key_held) sawActivity = 1'b1;
    end
    testsRun++;
    if (cnt != 8 || keyPadOut !== 4'b1110) begin
      testsFailed++;
      $display("[TB] FAIL glitch_resume: strobe moved after %0d cycles to %b, want 8 and 1110",
               cnt, keyPadOut);
    end
    repeat (20) begin
      @(negedge clk);
      if (key_valid || key_held) sawActivity = 1'b1;
    end
    testsRun++;
    if (sawActivity) begin
      testsFailed++;
      $display("[TB] FAIL glitch_nopush: valid/held seen=%b, want 0", sawActivity);
    end
  endtask

  task automatic test_overflow();
    logic       ok;
    logic       allOk;
    logic [3:0] code;
    logic       valid;
    key_ready = 1'b0;
    allOk = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(c, ok);
      allOk = allOk && ok;
    end
    testsRun++;
    if (!allOk || overflow !== 1'b0 || key_code !== 4'd1) begin
      testsFailed++;
      $display("[TB] FAIL ovf_fill: ok=%b ovf=%b head=%0d, want 1 0 1", allOk, overflow, key_code);
    end
    applyStimulus(5, ok);
    testsRun++;
    if (!ok || overflow !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL ovf_set: ok=%b ovf=%b, want 1 1", ok, overflow);
    end
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    testsRun++;
    if (overflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ovf_clear: ovf=%b, want 0", overflow);
    end
    for (int c = 1; c <= 4; c++) begin
      popOne(code, valid);
      testsRun++;
      if (valid !== 1'b1 || code !== 4'(c)) begin
        testsFailed++;
        $display("[TB] FAIL ovf_order: valid=%b code=%0d, want 1 %0d", valid, code, c);
      end
    end
    testsRun++;
    if (key_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ovf_drop: valid=%b after 4 pops, want 0", key_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic       ok;
    logic       allOk;
    logic [3:0] code;
    logic       valid;
    allOk = 1'b1;
    for (int c = 6; c <= 9; c++) begin
      applyStimulus(c, ok);
      allOk = allOk && ok;
    end
    testsRun++;
    if (!allOk || key_code !== 4'd6) begin
      testsFailed++;
      $display("[TB] FAIL b2b_fill: ok=%b head=%0d, want 1 6", allOk, key_code);
    end
    keysDown = '0;
    keysDown[10] = 1'b1;
    for (int i = 0; i < 200 && !key_held; i++) @(negedge clk);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    keysDown = '0;
    for (int i = 0; i < 200 && key_held; i++) @(negedge clk);
    testsRun++;
    if (overflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_no_ovf: ovf=%b, want 0", overflow);
    end
    for (int c = 7; c <= 10; c++) begin
      popOne(code, valid);
      testsRun++;
      if (valid !== 1'b1 || code !== 4'(c)) begin
        testsFailed++;
        $display("[TB] FAIL b2b_order: valid=%b code=%0d, want 1 %0d", valid, code, c);
      end
    end
    testsRun++;
    if (key_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_empty: valid=%b, want 0", key_valid);
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic sawValid;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    keysDown = 16'h0001;
    repeat (6) @(negedge clk);
    testsRun++;
    if (key_held !== 1'b0 || key_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL mid_db_state: held=%b valid=%b, want 0 0", key_held, key_valid);
    end
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (key_valid !== 1'b0 || keyPadOut !== 4'b0111 || key_held !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL mid_db_reset: valid=%b out=%b held=%b, want 0 0111 0",
               key_valid, keyPadOut, key_held);
    end
    keysDown = '0;
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (key_valid) sawValid = 1'b1;
    end
    testsRun++;
    if (sawValid) begin
      testsFailed++;
      $display("[TB] FAIL mid_db_discard: valid seen=%b after reset, want 0", sawValid);
    end
  endtask

  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    rst_n        = 1'b0;
    keysDown     = '0;
    key_ready    = 1'b0;
    overflow_clr = 1'b0;
    test_reset();
    test_single_key();
    test_code5();
    test_glitch();
    test_overflow();
    test_back_to_back();
    test_reset_mid_debounce();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
